// File: rtl/ddr3_dfi_rdcap_if.sv
// ddr3_dfi_rdcap_if: read-capture bus (issue side, DFI read return, assembled word out); master drives issue/DFI data, slave is the capture block
interface ddr3_dfi_rdcap_if;
  logic rd_issue_i;
  logic rd_partial_i;
  logic [2:0] rd_beats_i;
  logic accept_o;
  logic dfi_rddata_en_o;
  logic [31:0] dfi_rddata_i;
  logic dfi_rddata_valid_i;
  logic rddata_valid_o;
  logic [127:0] rddata_o;
  logic [2:0] rddata_beats_o;
  logic rddata_timeout_o;
  logic stray_o;
  logic busy_o;
  modport master (
    output rd_issue_i, rd_partial_i, rd_beats_i, dfi_rddata_i, dfi_rddata_valid_i,
    input accept_o, dfi_rddata_en_o, rddata_valid_o, rddata_o, rddata_beats_o, rddata_timeout_o, stray_o, busy_o
  );
  modport slave (
    input rd_issue_i, rd_partial_i, rd_beats_i, dfi_rddata_i, dfi_rddata_valid_i,
    output accept_o, dfi_rddata_en_o, rddata_valid_o, rddata_o, rddata_beats_o, rddata_timeout_o, stray_o, busy_o
  );
endinterface

// File: rtl/ddr3_dfi_rdcap.sv
// ddr3_dfi_rdcap: DDR3 DFI read capture; ports clk_i, rst_i (async high), bus (issue/accept, dfi_rddata_en/data/valid, 128-bit word out, timeout, stray, busy)
module ddr3_dfi_rdcap #(
  parameter int DDR_READ_LATENCY = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk_i,
  input logic rst_i,
  ddr3_dfi_rdcap_if.slave bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = DDR_READ_LATENCY + 3;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0] mem [QUEUE_DEPTH];
  logic [SW-1:0] sr;
  logic [127:0] word_q, word_n, rd_data;
  logic [2:0] idx, idx_n, idx_c, beats, head_n, rd_beats;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0] mask;
  logic accept, push, pop, more, cap, carry, done, tmo, rd_valid, rd_to, stray, valid;
  assign valid = bus.dfi_rddata_valid_i;
  assign accept = count < CW'(QUEUE_DEPTH);
  assign push = bus.rd_issue_i & accept;
  assign pop = state == EMIT;
  assign more = count > CW'(1);
  assign beats = (!bus.rd_partial_i || bus.rd_beats_i == 3'd0 || bus.rd_beats_i > 3'd4) ? 3'd4 : bus.rd_beats_i;
  assign mask = 4'b1111 >> (3'd4 - beats);
  assign head_n = mem[rd_ptr];
  assign cap = state == COLLECT && valid && idx < head_n;
  assign idx_c = idx + {2'b0, cap};
  assign done = idx_c >= head_n;
  assign tmo = tmr == TW'(TIMEOUT - 1);
  assign carry = state == EMIT && more && valid;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (count != '0 ? COLLECT : IDLE) :
              state == COLLECT ? (done || tmo ? EMIT : COLLECT) :
              (more ? COLLECT : IDLE);
  always_comb begin
    word_n = word_q;
    idx_n = idx;
    tmr_n = tmr;
    case (state)
      IDLE: begin
        word_n = '0;
        idx_n = '0;
        tmr_n = '0;
      end
      COLLECT: begin
        if (cap) word_n[idx[1:0]*32 +: 32] = bus.dfi_rddata_i;
        idx_n = idx_c;
        tmr_n = tmr + 1'b1;
      end
      default: begin
        word_n = carry ? {96'd0, bus.dfi_rddata_i} : '0;
        idx_n = {2'b0, carry};
        tmr_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      sr <= '0;
      word_q <= '0;
      idx <= '0;
      tmr <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_beats <= '0;
      rd_to <= 1'b0;
      stray <= 1'b0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      sr <= (sr >> 1) | (push ? SW'(mask) << (DDR_READ_LATENCY - 1) : '0);
      word_q <= word_n;
      idx <= idx_n;
      tmr <= tmr_n;
      rd_valid <= state == COLLECT && state_n == EMIT;
      if (state == COLLECT && state_n == EMIT) begin
        rd_data <= word_n;
        rd_beats <= idx_n;
        rd_to <= !done;
      end
      stray <= valid && (count == '0 || (state == EMIT && !more));
    end
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= beats;
  assign bus.accept_o = accept;
  assign bus.dfi_rddata_en_o = sr[0];
  assign bus.rddata_valid_o = rd_valid;
  assign bus.rddata_o = rd_data;
  assign bus.rddata_beats_o = rd_beats;
  assign bus.rddata_timeout_o = rd_to;
  assign bus.stray_o = stray;
  assign bus.busy_o = count != '0 || sr != '0;
endmodule

// File: tb/tb_ddr3_dfi_rdcap.sv
// tb_ddr3_dfi_rdcap: table-driven and scoreboard bench for ddr3_dfi_rdcap
module tb_ddr3_dfi_rdcap;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;
  ddr3_dfi_rdcap_if bus();
  ddr3_dfi_rdcap dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  typedef struct {logic [127:0] data; logic [2:0] beats; logic to;} exp_t;
  typedef struct {logic partial; logic [2:0] beats_in; int n;} vec_t;
  exp_t sb[$];
  logic [31:0] beat_q[$];
  vec_t vecs[10];
  int checks = 0, failures = 0, cyc = 0, en_cnt = 0, en_first = -1, word_cyc = -1, feed = 0, stray_cnt = 0, issue_cyc = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    cyc++;
    if (bus.dfi_rddata_en_o) begin
      en_cnt++;
      if (en_first < 0) en_first = cyc;
    end
    if (bus.stray_o) stray_cnt++;
    if (bus.rddata_valid_o) begin
      word_cyc = cyc;
      if (sb.size() == 0) chk("word_unexpected", {127'd0, bus.rddata_valid_o}, 128'd0);
      else begin
        e = sb.pop_front();
        chk("word_data", bus.rddata_o, e.data);
        chk("word_beats", 128'(bus.rddata_beats_o), 128'(e.beats));
        chk("word_timeout", 128'(bus.rddata_timeout_o), 128'(e.to));
      end
    end
    if (((feed == 1 && bus.dfi_rddata_en_o) || feed == 2) && beat_q.size() > 0) begin
      bus.dfi_rddata_valid_i = 1'b1;
      bus.dfi_rddata_i = beat_q.pop_front();
    end else bus.dfi_rddata_valid_i = 1'b0;
  endtask
  task automatic issue(input logic p, input logic [2:0] b, input int nret, input bit exp_acc, input bit to);
    exp_t e;
    logic [31:0] d;
    chk("accept", 128'(bus.accept_o), 128'(exp_acc));
    bus.rd_issue_i = 1'b1;
    bus.rd_partial_i = p;
    bus.rd_beats_i = b;
    if (exp_acc) begin
      e.data = '0;
      for (int k = 0; k < nret; k++) begin
        d = $urandom;
        e.data[k*32 +: 32] = d;
        beat_q.push_back(d);
      end
      e.beats = 3'(nret);
      e.to = to;
      sb.push_back(e);
    end
    issue_cyc = cyc;
    tick();
    bus.rd_issue_i = 1'b0;
  endtask
  task automatic wait_words(input int lim);
    int k = 0;
    while (sb.size() > 0 && k < lim) begin
      tick();
      k++;
    end
    chk("words_pending", 128'(sb.size()), 128'd0);
  endtask
  initial begin
    int t, s0;
    vecs[0] = '{1'b0, 3'd0, 4};
    vecs[1] = '{1'b0, 3'd2, 4};
    vecs[2] = '{1'b1, 3'd0, 4};
    vecs[3] = '{1'b1, 3'd1, 1};
    vecs[4] = '{1'b1, 3'd2, 2};
    vecs[5] = '{1'b1, 3'd3, 3};
    vecs[6] = '{1'b1, 3'd4, 4};
    vecs[7] = '{1'b1, 3'd5, 4};
    vecs[8] = '{1'b1, 3'd6, 4};
    vecs[9] = '{1'b1, 3'd7, 4};
    bus.rd_issue_i = 1'b0;
    bus.rd_partial_i = 1'b0;
    bus.rd_beats_i = 3'd0;
    bus.dfi_rddata_i = '0;
    bus.dfi_rddata_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("rst_accept", 128'(bus.accept_o), 128'd1);
    chk("rst_en", 128'(bus.dfi_rddata_en_o), 128'd0);
    chk("rst_valid", 128'(bus.rddata_valid_o), 128'd0);
    chk("rst_data", bus.rddata_o, 128'd0);
    chk("rst_beats", 128'(bus.rddata_beats_o), 128'd0);
    chk("rst_stray", 128'(bus.stray_o), 128'd0);
    chk("rst_busy", 128'(bus.busy_o), 128'd0);
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (2) tick();
    // one read per table row: enable timing, burst length and word latency
    for (int i = 0; i < 10; i++) begin
      en_cnt = 0;
      en_first = -1;
      feed = 1;
      issue(vecs[i].partial, vecs[i].beats_in, vecs[i].n, 1'b1, 1'b0);
      t = issue_cyc;
      wait_words(40);
      chk("en_first", 128'(en_first), 128'(t + 4));
      chk("en_count", 128'(en_cnt), 128'(vecs[i].n));
      chk("word_latency", 128'(word_cyc), 128'(t + 4 + vecs[i].n));
      repeat (3) tick();
    end
    // queue full: four accepted, fifth dropped, then 16 beats streamed
    en_cnt = 0;
    feed = 0;
    s0 = stray_cnt;
    for (int i = 0; i < 4; i++) issue(1'b0, 3'd0, 4, 1'b1, 1'b0);
    issue(1'b0, 3'd0, 4, 1'b0, 1'b0);
    repeat (12) tick();
    chk("full_en_count", 128'(en_cnt), 128'd7);
    chk("full_words_queued", 128'(sb.size()), 128'd4);
    feed = 2;
    wait_words(60);
    chk("full_no_stray", 128'(stray_cnt), 128'(s0));
    repeat (3) tick();
    chk("full_idle", 128'(bus.busy_o), 128'd0);
    // timeout: one beat returned of four
    feed = 1;
    issue(1'b0, 3'd0, 1, 1'b1, 1'b1);
    t = issue_cyc;
    chk("to_busy", 128'(bus.busy_o), 128'd1);
    wait_words(100);
    chk("to_latency", 128'(word_cyc), 128'(t + 66));
    tick();
    chk("to_idle", 128'(bus.busy_o), 128'd0);
    // stray beat with empty queue
    feed = 0;
    bus.dfi_rddata_i = 32'hdeadbeef;
    bus.dfi_rddata_valid_i = 1'b1;
    tick();
    chk("stray_pulse", 128'(bus.stray_o), 128'd1);
    tick();
    chk("stray_single", 128'(bus.stray_o), 128'd0);
    // async reset in the middle of a collect
    feed = 1;
    issue(1'b0, 3'd0, 2, 1'b1, 1'b0);
    t = issue_cyc;
    while (cyc < t + 6) tick();
    chk("mid_en", 128'(bus.dfi_rddata_en_o), 128'd1);
    #2 rst_i = 1'b1;
    #1;
    sb.delete();
    beat_q.delete();
    chk("mid_rst_accept", 128'(bus.accept_o), 128'd1);
    chk("mid_rst_en", 128'(bus.dfi_rddata_en_o), 128'd0);
    chk("mid_rst_busy", 128'(bus.busy_o), 128'd0);
    chk("mid_rst_data", bus.rddata_o, 128'd0);
    chk("mid_rst_timeout", 128'(bus.rddata_timeout_o), 128'd0);
    chk("mid_rst_beats", 128'(bus.rddata_beats_o), 128'd0);
    feed = 0;
    tick();
    rst_i = 1'b0;
    tick();
    bus.dfi_rddata_i = 32'h12345678;
    bus.dfi_rddata_valid_i = 1'b1;
    tick();
    chk("post_rst_stray", 128'(bus.stray_o), 128'd1);
    repeat (5) tick();
    chk("post_rst_idle", 128'(bus.busy_o), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
